// File: rtl/lfsr_engine.sv
// lfsr_engine: Fibonacci/Galois LFSR with an output word packer and valid/ready handshake.
// Optional all-zero lockup recovery is enabled by defining LFSR_LOCKUP_RECOVER_EN.
module lfsr_engine #(
  parameter int unsigned       WIDTH = 8,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(8'hB8),
  parameter int unsigned       MODE  = 0,
  parameter logic [WIDTH-1:0]  SEED  = WIDTH'(32'd1),
  parameter int unsigned       OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state,
  output logic             bit_out,
  output logic [OUT_W-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             wrap,
  output logic             lockup
);

  localparam int unsigned     CNT_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

  function automatic logic fb_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    if (MODE == 32'd1) begin
      r = (s >> 1'b1) ^ (s[0] ? TAPS : {WIDTH{1'b0}});
    end else begin
      r = {s[WIDTH-2:0], fb_parity(s & TAPS)};
    end
    return r;
  endfunction

  logic [WIDTH-1:0] state_r, ref_r, step_s, state_nx_s, ref_nx_s;
  logic [OUT_W-1:0] pack_r, pack_nx_s, shifted_s, word_r, word_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic             word_valid_r, word_valid_nx_s;
  logic             wrap_r, wrap_nx_s, lockup_r, lockup_nx_s;
  logic             bit_s, last_s, stall_s, adv_s, zero_s, new_word_s;

  // Next-state decode: load beats advance; a completed word can land while the old one is consumed.
  always_comb begin
    step_s    = lfsr_step(state_r);
    bit_s     = (MODE == 32'd1) ? state_r[0] : state_r[WIDTH-1];
    last_s    = (cnt_r == CNT_LAST);
    stall_s   = word_valid_r & ~word_ready & last_s;
    adv_s     = en & ~load & ~stall_s;
    shifted_s = {pack_r[OUT_W-2:0], bit_s};
`ifdef LFSR_LOCKUP_RECOVER_EN
    zero_s    = (state_r == {WIDTH{1'b0}});
`else
    zero_s    = 1'b0;
`endif
    state_nx_s  = state_r;
    ref_nx_s    = ref_r;
    pack_nx_s   = pack_r;
    cnt_nx_s    = cnt_r;
    word_nx_s   = word_r;
    wrap_nx_s   = 1'b0;
    lockup_nx_s = 1'b0;
    new_word_s  = 1'b0;
    if (load) begin
      state_nx_s = seed_in;
      ref_nx_s   = seed_in;
      pack_nx_s  = {OUT_W{1'b0}};
      cnt_nx_s   = {CNT_W{1'b0}};
    end else if (adv_s && zero_s) begin
      state_nx_s  = SEED;
      ref_nx_s    = SEED;
      pack_nx_s   = {OUT_W{1'b0}};
      cnt_nx_s    = {CNT_W{1'b0}};
      lockup_nx_s = 1'b1;
    end else if (adv_s) begin
      state_nx_s = step_s;
      pack_nx_s  = shifted_s;
      wrap_nx_s  = (step_s == ref_r);
      if (last_s) begin
        word_nx_s  = shifted_s;
        cnt_nx_s   = {CNT_W{1'b0}};
        new_word_s = 1'b1;
      end else begin
        cnt_nx_s   = cnt_r + CNT_W'(1'b1);
      end
    end else begin
      state_nx_s = state_r;
    end
    if (new_word_s) begin
      word_valid_nx_s = 1'b1;
    end else if (word_valid_r && word_ready) begin
      word_valid_nx_s = 1'b0;
    end else begin
      word_valid_nx_s = word_valid_r;
    end
  end

  // State registers with asynchronous reset to the seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= SEED;
      ref_r        <= SEED;
      pack_r       <= {OUT_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      word_r       <= {OUT_W{1'b0}};
      word_valid_r <= 1'b0;
      wrap_r       <= 1'b0;
      lockup_r     <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      ref_r        <= ref_nx_s;
      pack_r       <= pack_nx_s;
      cnt_r        <= cnt_nx_s;
      word_r       <= word_nx_s;
      word_valid_r <= word_valid_nx_s;
      wrap_r       <= wrap_nx_s;
      lockup_r     <= lockup_nx_s;
    end
  end

  assign state      = state_r;
  assign bit_out    = bit_s;
  assign word_out   = word_r;
  assign word_valid = word_valid_r;
  assign wrap       = wrap_r;
  assign lockup     = lockup_r;

endmodule

// File: tb/tb_lfsr_engine.sv
// Self-checking bench for lfsr_engine: a Fibonacci and a Galois instance driven in lockstep
// against an arithmetic reference model; honours LFSR_LOCKUP_RECOVER_EN like the design.
module tb_lfsr_engine;
  localparam logic [7:0] TAPS = 8'hB8;
  localparam logic [7:0] SEED = 8'h01;
`ifdef LFSR_LOCKUP_RECOVER_EN
  localparam bit RECOVER = 1'b1;
`else
  localparam bit RECOVER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, load, word_ready;
  logic [7:0] seed_in;
  logic [7:0] st_o [2];
  logic [7:0] wo_o [2];
  logic       bit_o [2];
  logic       wv_o [2];
  logic       wrap_o [2];
  logic       lock_o [2];

  int checks;
  int failures;

  // reference model: per-instance state plus the bits gathered for the current word
  logic [7:0] m_st [2];
  logic [7:0] m_ref [2];
  logic [7:0] m_wo [2];
  bit         m_wv [2];
  bit         m_wrap [2];
  bit         m_lock [2];
  bit         m_bits [2][8];
  int         m_n [2];

  always #5 clk = ~clk;

  lfsr_engine #(.WIDTH(8), .TAPS(8'hB8), .MODE(0), .SEED(8'h01), .OUT_W(8)) dut0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
    .state(st_o[0]), .bit_out(bit_o[0]), .word_out(wo_o[0]), .word_valid(wv_o[0]),
    .word_ready(word_ready), .wrap(wrap_o[0]), .lockup(lock_o[0]));

  lfsr_engine #(.WIDTH(8), .TAPS(8'hB8), .MODE(1), .SEED(8'h01), .OUT_W(8)) dut1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
    .state(st_o[1]), .bit_out(bit_o[1]), .word_out(wo_o[1]), .word_valid(wv_o[1]),
    .word_ready(word_ready), .wrap(wrap_o[1]), .lockup(lock_o[1]));

  function automatic logic [7:0] m_next(int m, logic [7:0] s);
    int v;
    v = int'(s);
    if (m == 0) return 8'(((v * 2) % 256) + ($countones(s & TAPS) % 2));
    else        return 8'(v / 2) ^ (((v % 2) == 1) ? TAPS : 8'h00);
  endfunction

  function automatic bit m_bit(int m, logic [7:0] s);
    int v;
    v = int'(s);
    if (m == 0) return bit'(v / 128);
    else        return bit'(v % 2);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_st[m] = SEED; m_ref[m] = SEED; m_wo[m] = 8'h00;
      m_wv[m] = 1'b0; m_wrap[m] = 1'b0; m_lock[m] = 1'b0; m_n[m] = 0;
    end
  endtask

  task automatic model_step(int m);
    bit stall, nw;
    logic [7:0] nxt, w;
    stall = m_wv[m] && !word_ready && (m_n[m] == 7);
    nw = 1'b0; m_wrap[m] = 1'b0; m_lock[m] = 1'b0;
    if (load) begin
      m_st[m] = seed_in; m_ref[m] = seed_in; m_n[m] = 0;
    end else if (en && !stall) begin
      if (RECOVER && m_st[m] == 8'h00) begin
        m_st[m] = SEED; m_ref[m] = SEED; m_n[m] = 0; m_lock[m] = 1'b1;
      end else begin
        m_bits[m][m_n[m]] = m_bit(m, m_st[m]);
        m_n[m]++;
        nxt = m_next(m, m_st[m]);
        m_wrap[m] = (nxt == m_ref[m]);
        m_st[m] = nxt;
        if (m_n[m] == 8) begin
          w = 8'h00;
          for (int i = 0; i < 8; i++) w = 8'((w * 2) + m_bits[m][i]);
          m_wo[m] = w; m_n[m] = 0; nw = 1'b1;
        end
      end
    end
    if (nw) m_wv[m] = 1'b1;
    else if (m_wv[m] && word_ready) m_wv[m] = 1'b0;
  endtask

  task automatic check_all(string ph);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("%s.m%0d.state", ph, m), 32'(st_o[m]), 32'(m_st[m]));
      check($sformatf("%s.m%0d.bit_out", ph, m), 32'(bit_o[m]), 32'(m_bit(m, m_st[m])));
      check($sformatf("%s.m%0d.word_out", ph, m), 32'(wo_o[m]), 32'(m_wo[m]));
      check($sformatf("%s.m%0d.word_valid", ph, m), 32'(wv_o[m]), 32'(m_wv[m]));
      check($sformatf("%s.m%0d.wrap", ph, m), 32'(wrap_o[m]), 32'(m_wrap[m]));
      check($sformatf("%s.m%0d.lockup", ph, m), 32'(lock_o[m]), 32'(m_lock[m]));
    end
  endtask

  task automatic tick(string ph);
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  int         wrap_cnt [2];
  int         wv_cnt;
  int         distinct;
  bit         seen [256];
  logic [7:0] exp_st;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; en = 1'b0; load = 1'b0; word_ready = 1'b0; seed_in = 8'h00;
    model_reset();
    #2;
    check_all("reset_async");
    @(posedge clk); #1;
    check_all("reset_hold");
    rst = 1'b0;

    // full period: wrap once after 255 advances, Galois visits 255 distinct states
    en = 1'b1; word_ready = 1'b1;
    wrap_cnt[0] = 0; wrap_cnt[1] = 0; wv_cnt = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    seen[SEED] = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick("period");
      if (wrap_o[0]) wrap_cnt[0]++;
      if (wrap_o[1]) wrap_cnt[1]++;
      if (wv_o[1]) wv_cnt++;
      if (i < 255) seen[st_o[1]] = 1'b1;
    end
    distinct = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
    check("period.wrap_once_m0", 32'(wrap_cnt[0]), 32'd1);
    check("period.wrap_once_m1", 32'(wrap_cnt[1]), 32'd1);
    check("period.wrap_last_m0", 32'(wrap_o[0]), 32'd1);
    check("period.state_m0", 32'(st_o[0]), 32'h01);
    check("period.state_m1", 32'(st_o[1]), 32'h01);
    check("period.words_m1", 32'(wv_cnt), 32'd31);
    check("period.distinct_m1", 32'(distinct), 32'd255);
    check("period.zero_unseen_m1", 32'(seen[0]), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      en         = ($urandom_range(0, 3) != 0);
      word_ready = 1'($urandom_range(0, 1));
      load       = ($urandom_range(0, 19) == 0);
      seed_in    = 8'($urandom_range(1, 255));
      tick("rand");
    end
    load = 1'b0;

    // backpressure: first word pending, second stalls with seven bits packed
    rst = 1'b1; #1;
    model_reset();
    check_all("rst2");
    rst = 1'b0;
    en = 1'b1; word_ready = 1'b0;
    for (int i = 0; i < 24; i++) tick("stall");
    exp_st = SEED;
    for (int i = 0; i < 15; i++) exp_st = m_next(0, exp_st);
    check("stall.frozen_m0", 32'(st_o[0]), 32'(exp_st));
    check("stall.valid_m0", 32'(wv_o[0]), 32'd1);
    word_ready = 1'b1;
    tick("resume");
    exp_st = m_next(0, exp_st);
    check("resume.state_m0", 32'(st_o[0]), 32'(exp_st));
    check("resume.valid_m0", 32'(wv_o[0]), 32'd1);
    word_ready = 1'b0;

    // load beats en and leaves the pending word alone
    load = 1'b1; seed_in = 8'h5A;
    tick("load");
    check("load.state_m0", 32'(st_o[0]), 32'h5A);
    check("load.state_m1", 32'(st_o[1]), 32'h5A);
    check("load.valid_m0", 32'(wv_o[0]), 32'd1);
    load = 1'b0; word_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick("after_load");

    // all-zero state
    load = 1'b1; en = 1'b0; seed_in = 8'h00;
    tick("load_zero");
    load = 1'b0; en = 1'b1;
    tick("lockup");
    check("lockup.state_m0", 32'(st_o[0]), RECOVER ? 32'h01 : 32'h00);
    check("lockup.state_m1", 32'(st_o[1]), RECOVER ? 32'h01 : 32'h00);
    check("lockup.pulse_m0", 32'(lock_o[0]), 32'(RECOVER));
    tick("lockup_after");
    load = 1'b1; seed_in = SEED;
    tick("reload");
    load = 1'b0;

    // asynchronous reset mid-word with a pending word
    word_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick("pre_rst");
    check("pre_rst.valid_m0", 32'(wv_o[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst.state_m0", 32'(st_o[0]), 32'(SEED));
    check("async_rst.valid_m1", 32'(wv_o[1]), 32'd0);
    rst = 1'b0;
    word_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_engine.md
LFSR_ENGINE -- requirements
Module: lfsr_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, LFSR state width (3..32).
REQ-002 SHALL have parameter TAPS, default 8'hB8, feedback tap mask, WIDTH bits.
REQ-003 SHALL have parameter MODE, default 0, 0 = Fibonacci, 1 = Galois.
REQ-004 SHALL have parameter SEED, default 1, reset/recovery state; nonzero.
REQ-005 SHALL have parameter OUT_W, default 8, packed output word width (2..32).
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port en  input  1  advance request, one step per cycle.
REQ-009 SHALL have port load  input  1  synchronous load of seed_in.
REQ-010 SHALL have port seed_in  input  WIDTH  value loaded on load.
REQ-011 SHALL have port state  output  WIDTH  current LFSR state.
REQ-012 SHALL have port bit_out  output  1  bit shifted out by the current state.
REQ-013 SHALL have port word_out  output  OUT_W  last completed packed word.
REQ-014 SHALL have port word_valid  output  1  word_out holds an unconsumed word.
REQ-015 SHALL have port word_ready  input  1  consumer accepts word_out when high with word_valid.
REQ-016 SHALL have port wrap  output  1  one-cycle pulse when state returns to the last loaded value.
REQ-017 SHALL have port lockup  output  1  one-cycle pulse on all-zero recovery.

Function
REQ-018 SHALL, MODE 0: bit_out = state[WIDTH-1]; step = {state[WIDTH-2:0], XOR of state bits selected by TAPS}.
REQ-019 SHALL, MODE 1: bit_out = state[0]; step = (state >> 1) XOR (state[0] ? TAPS : 0).
REQ-020 SHALL define stall = word_valid & ~word_ready & (bit_cnt == OUT_W-1).
REQ-021 SHALL advance state one step when en & ~load & ~stall; otherwise hold it.
REQ-022 SHALL, on each advance, shift bit_out into an internal packer LSB-first-in ({pack[OUT_W-2:0], bit_out}) and increment bit_cnt.
REQ-023 SHALL, on the advance with bit_cnt == OUT_W-1, copy the completed packer value to word_out, set word_valid, and wrap bit_cnt to 0.
REQ-024 SHALL clear word_valid on a cycle with word_valid & word_ready unless a new word completes in that same cycle, in which case word_valid stays 1 with the new word.
REQ-025 SHALL, on load, set state = seed_in, clear bit_cnt and the packer, leave word_out/word_valid untouched; load has priority over en.
REQ-026 SHALL record the loaded value (SEED after reset) as the reference; wrap pulses the cycle after an advance whose next state equals the reference.
REQ-027 SHALL never stall while word_valid is low or word_ready is high; latency from the first advance to word_valid is OUT_W cycles.

Reset
REQ-028 SHALL, on rst, set state = SEED, reference = SEED, bit_cnt = 0, packer = 0, word_out = 0, word_valid = 0, wrap = 0, lockup = 0.
REQ-029 SHALL apply reset asynchronously mid-operation, discarding any pending word.

Configuration
REQ-030 SHALL, with LFSR_LOCKUP_RECOVER_EN defined, replace an advance from all-zero state with a load of SEED (reference = SEED, packer/bit_cnt cleared) and pulse lockup for one cycle.
REQ-031 SHALL, without LFSR_LOCKUP_RECOVER_EN, let the all-zero state persist (MODE 0/1 step keeps zero) and tie lockup to 0.

Verification
REQ-032 SHALL cover: reset, MODE 0 defaults, en=1 for 255 cycles -> wrap pulses once after the 255th advance, state = 8'h01.
REQ-033 SHALL cover: MODE 1 defaults, en=1, word_ready=1 -> word_valid every 8 cycles, 255 distinct nonzero states before wrap.
REQ-034 SHALL cover: word_ready=0, en=1 -> after 2nd word completes pending, state freezes at bit_cnt=7; raising word_ready resumes within 1 cycle, no bit lost.
REQ-035 SHALL cover: load=1 and en=1 with seed_in=8'h5A -> next state 8'h5A, bit_cnt=0, word_valid unchanged.
REQ-036 SHALL cover: load seed_in=0 then en=1 -> with macro, state=8'h01 and lockup pulse; without, state stays 0, lockup 0.
REQ-037 SHALL cover: rst asserted mid-word with word_valid=1 -> state=SEED and word_valid=0 immediately, without a clock edge.
